// File: rtl/word_splitter_stream.sv
// Word splitter: accepts one WORD_W-bit word and streams it out as N = WORD_W/CHUNK_W
// chunks, least- or most-significant chunk first, with valid/ready handshakes on both sides.
module word_splitter_stream #(
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned CHUNK_W = 8,
  localparam int unsigned N      = WORD_W / CHUNK_W,
  localparam int unsigned IDX_W  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_data,
  input  logic               in_msb_first,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CHUNK_W-1:0] out_data,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_last,
  output logic               busy
);

  // Refuse to build when the word does not divide into at least two whole chunks.
  if (((WORD_W % CHUNK_W) != 0) || ((WORD_W / CHUNK_W) < 2)) begin : g_param_check
    $error("word_splitter_stream: WORD_W must be a multiple of CHUNK_W with N >= 2");
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(N - 1);

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  hold_q, hold_d;
  logic               msb_q, msb_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;

  logic               valid_c;
  logic               last_c;
  logic               accept_c;
  logic               xfer_c;
  logic [IDX_W-1:0]   slice_c;
  logic [WORD_W-1:0]  shifted_c;

  assign valid_c  = (state_q == ST_SEND);
  assign last_c   = valid_c && (cnt_q == CNT_LAST);
  assign in_ready = !valid_c || (out_ready && last_c);
  assign accept_c = in_valid && in_ready;
  assign xfer_c   = valid_c && out_ready;

  // Slice to present: counter order for LSB-first, mirrored for MSB-first.
  always_comb begin
    slice_c   = msb_q ? (CNT_LAST - cnt_q) : cnt_q;
    shifted_c = hold_q >> (int'(slice_c) * int'(CHUNK_W));
  end

  // Chunk outputs come straight from state and are forced to zero while idle.
  always_comb begin
    out_valid = valid_c;
    busy      = valid_c;
    out_data  = '0;
    out_idx   = '0;
    out_last  = 1'b0;
    if (valid_c) begin
      out_data = shifted_c[CHUNK_W-1:0];
      out_idx  = slice_c;
      out_last = last_c;
    end
  end

  // Next state: a new word wins (it can only arrive on the last-chunk transfer), otherwise advance.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    msb_d   = msb_q;
    cnt_d   = cnt_q;
    if (accept_c) begin
      state_d = ST_SEND;
      hold_d  = in_data;
      msb_d   = in_msb_first;
      cnt_d   = '0;
    end else if (xfer_c) begin
      if (last_c) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_q + IDX_W'(1);
      end
    end
  end

  // State registers; reset drops any partially sent word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      msb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      msb_q   <= msb_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_word_splitter_stream.sv
// Bench for word_splitter_stream: directed scenarios plus random traffic against a chunk-queue model,
// and a 16/4 build variant checked with a fixed sequence.
module tb_word_splitter_stream;

  localparam int unsigned WW = 32;
  localparam int unsigned CW = 8;
  localparam int unsigned NN = WW / CW;
  localparam int unsigned IW = $clog2(NN);

  logic          clk;
  logic          rst_n;
  logic          in_valid, in_ready, in_msb_first;
  logic [WW-1:0] in_data;
  logic          out_valid, out_ready, out_last, busy;
  logic [CW-1:0] out_data;
  logic [IW-1:0] out_idx;

  logic        v_in_valid, v_in_ready, v_in_msb_first;
  logic [15:0] v_in_data;
  logic        v_out_valid, v_out_ready, v_out_last, v_busy;
  logic [3:0]  v_out_data;
  logic [1:0]  v_out_idx;

  int unsigned n_checks;
  int unsigned n_pass;

  typedef struct packed {
    logic [CW-1:0] data;
    logic [IW-1:0] idx;
    logic          last;
  } chunk_t;

  chunk_t exp_q[$];

  word_splitter_stream #(.WORD_W(WW), .CHUNK_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_msb_first(in_msb_first),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .busy(busy)
  );

  word_splitter_stream #(.WORD_W(16), .CHUNK_W(4)) dut_v (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v_in_valid), .in_ready(v_in_ready), .in_data(v_in_data), .in_msb_first(v_in_msb_first),
    .out_valid(v_out_valid), .out_ready(v_out_ready), .out_data(v_out_data), .out_idx(v_out_idx),
    .out_last(v_out_last), .busy(v_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Model: an accepted word becomes N chunks in emission order.
  function automatic void push_word(input logic [WW-1:0] w, input logic msb);
    for (int k = 0; k < int'(NN); k++) begin
      chunk_t c;
      int     s;
      s      = msb ? (int'(NN) - 1 - k) : k;
      c.data = CW'(w >> (s * int'(CW)));
      c.idx  = IW'(s);
      c.last = (k == int'(NN) - 1);
      exp_q.push_back(c);
    end
  endfunction

  // One clock: drive at the falling edge, check, then advance the model at the rising edge.
  task automatic cycle(input logic v, input logic [WW-1:0] d, input logic m, input logic r);
    logic   e_valid, e_ready, acc, xf;
    chunk_t h;
    in_valid = v; in_data = d; in_msb_first = m; out_ready = r;
    #1;
    e_valid = (exp_q.size() != 0);
    h = '0;
    if (e_valid) h = exp_q[0];
    e_ready = !e_valid || (r && h.last);
    check_eq("out_valid", 32'(out_valid), 32'(e_valid));
    check_eq("busy", 32'(busy), 32'(e_valid));
    check_eq("out_data", 32'(out_data), 32'(h.data));
    check_eq("out_idx", 32'(out_idx), 32'(h.idx));
    check_eq("out_last", 32'(out_last), 32'(h.last));
    check_eq("in_ready", 32'(in_ready), 32'(e_ready));
    acc = v && e_ready;
    xf  = e_valid && r;
    @(posedge clk);
    if (xf) void'(exp_q.pop_front());
    if (acc) push_word(d, m);
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst out_valid", 32'(out_valid), 32'd0);
    check_eq("rst out_data", 32'(out_data), 32'd0);
    check_eq("rst out_idx", 32'(out_idx), 32'd0);
    check_eq("rst out_last", 32'(out_last), 32'd0);
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] vexp [4];
    n_checks = 0; n_pass = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_msb_first = 1'b0; out_ready = 1'b1;
    v_in_valid = 1'b0; v_in_data = '0; v_in_msb_first = 1'b0; v_out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(1);
    do_reset();
    idle_cycles(1);

    // LSB-first and MSB-first single words.
    cycle(1'b1, 32'h12345678, 1'b0, 1'b1);
    idle_cycles(5);
    cycle(1'b1, 32'h12345678, 1'b1, 1'b1);
    idle_cycles(5);

    // Backpressure on the second chunk while new words are offered and must be ignored.
    cycle(1'b1, 32'h12345678, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
    idle_cycles(4);

    // Back-to-back words with in_valid held.
    cycle(1'b1, 32'hAABBCCDD, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h11223344, 1'b0, 1'b1);
    idle_cycles(5);

    // Reset mid-word, then a fresh word must restart at slice 0.
    cycle(1'b1, 32'hAABBCCDD, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    do_reset();
    cycle(1'b1, 32'hCAFEF00D, 1'b0, 1'b1);
    idle_cycles(5);

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 1500; i++) begin
      if ((i % 500) == 250) do_reset();
      cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0));
    end
    idle_cycles(5);

    // 16-bit word / 4-bit chunk variant, LSB-first 0xABCD.
    vexp[0] = 4'hD; vexp[1] = 4'hC; vexp[2] = 4'hB; vexp[3] = 4'hA;
    v_in_valid = 1'b1; v_in_data = 16'hABCD; v_in_msb_first = 1'b0; v_out_ready = 1'b1;
    #1 check_eq("v in_ready idle", 32'(v_in_ready), 32'd1);
    @(negedge clk);
    v_in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_eq("v out_valid", 32'(v_out_valid), 32'd1);
      check_eq("v out_data", 32'(v_out_data), 32'(vexp[k]));
      check_eq("v out_idx", 32'(v_out_idx), 32'(k));
      check_eq("v out_last", 32'(v_out_last), 32'(k == 3));
      check_eq("v in_ready", 32'(v_in_ready), 32'(k == 3));
      @(negedge clk);
    end
    #1 check_eq("v out_valid end", 32'(v_out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
